// File: rtl/alu_share_arbiter_if.sv
// Bundles the two requester ports, the shared response path and the ALU
// operand/result bus between the arbiter and its surroundings.
interface alu_share_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
);
    logic              req0_valid;
    logic              req0_ready;
    logic [WIDTH-1:0]  req0_a;
    logic [WIDTH-1:0]  req0_b;
    logic [CTRL_W-1:0] req0_ctrl;
    logic              req1_valid;
    logic              req1_ready;
    logic [WIDTH-1:0]  req1_a;
    logic [WIDTH-1:0]  req1_b;
    logic [CTRL_W-1:0] req1_ctrl;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [WIDTH-1:0]  rsp_out;
    logic              rsp_zero;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [WIDTH-1:0]  alu_out;
    logic              alu_zero;
    logic              busy;
    logic              grant;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        input  rsp0_ready, rsp1_ready, alu_out, alu_zero,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_out, rsp_zero, alu_a, alu_b, alu_ctrl, busy, grant
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        output rsp0_ready, rsp1_ready, alu_out, alu_zero,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_out, rsp_zero, alu_a, alu_b, alu_ctrl, busy, grant
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters:
// accept -> drive ALU from registered operands -> hold result until consumed.
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              grant_q;
    logic              winner;
    logic              req_any;
    logic              rsp_hs;
    logic [WIDTH-1:0]  op_a_p0;
    logic [WIDTH-1:0]  op_b_p0;
    logic [CTRL_W-1:0] op_ctrl_p0;
    logic [WIDTH-1:0]  rsp_out_p1;
    logic              rsp_zero_p1;

    // Ties go to the port that did not win last; a lone requester always wins.
    always_comb begin
        req_any = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            winner = ~last_grant;
        else
            winner = bus.req1_valid;
        rsp_hs = grant_q ? bus.rsp1_ready : bus.rsp0_ready;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (state == IDLE && req_any)
                grant_q <= winner;
            if (state == RESP && rsp_hs)
                last_grant <= grant_q;
        end
    end

    // Stage p0: operands latched at acceptance feed the ALU through EXEC and beyond.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_p0    <= '0;
            op_b_p0    <= '0;
            op_ctrl_p0 <= '0;
        end else if (state == IDLE && req_any) begin
            op_a_p0    <= winner ? bus.req1_a    : bus.req0_a;
            op_b_p0    <= winner ? bus.req1_b    : bus.req0_b;
            op_ctrl_p0 <= winner ? bus.req1_ctrl : bus.req0_ctrl;
        end
    end

    // Stage p1: ALU result captured at the end of EXEC and held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_out_p1  <= '0;
            rsp_zero_p1 <= 1'b0;
        end else if (state == EXEC) begin
            rsp_out_p1  <= bus.alu_out;
            rsp_zero_p1 <= bus.alu_zero;
        end
    end

    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req0_ready = bus.req0_valid & ~winner;
                bus.req1_ready = bus.req1_valid &  winner;
            end
            RESP: begin
                bus.rsp0_valid = ~grant_q;
                bus.rsp1_valid =  grant_q;
            end
            default: ;
        endcase
        bus.busy = (state != IDLE);
    end

    assign bus.alu_a    = op_a_p0;
    assign bus.alu_b    = op_b_p0;
    assign bus.alu_ctrl = op_ctrl_p0;
    assign bus.rsp_out  = rsp_out_p1;
    assign bus.rsp_zero = rsp_zero_p1;
    assign bus.grant    = grant_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural 32-bit ALU attached.
module tb_alu_share_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_share_arbiter_if #(.WIDTH(32), .CTRL_W(3)) bus ();

    alu_share_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        case (bus.alu_ctrl)
            3'b000:  bus.alu_out = bus.alu_a & bus.alu_b;
            3'b001:  bus.alu_out = bus.alu_a | bus.alu_b;
            3'b010:  bus.alu_out = bus.alu_a + bus.alu_b;
            3'b011:  bus.alu_out = bus.alu_a - bus.alu_b;
            3'b100:  bus.alu_out = (bus.alu_a < bus.alu_b) ? 32'd1 : 32'd0;
            default: bus.alu_out = ~bus.alu_a;
        endcase
        bus.alu_zero = (bus.alu_out == 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit port, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] ctrl);
        if (port) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = ctrl;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = ctrl;
        end
    endtask

    // Single transaction on an otherwise idle arbiter, responder always ready.
    task automatic txn(input string tag, input bit port, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] ctrl,
                       input logic [31:0] exp_out, input logic exp_zero);
        drive(port, a, b, ctrl);
        #1;
        chk({tag, "_rdy"}, {31'd0, port ? bus.req1_ready : bus.req0_ready}, 32'd1);
        chk({tag, "_rdy_other"}, {31'd0, port ? bus.req0_ready : bus.req1_ready}, 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk({tag, "_alu_a"}, bus.alu_a, a);
        chk({tag, "_alu_ctrl"}, {29'd0, bus.alu_ctrl}, {29'd0, ctrl});
        chk({tag, "_grant"}, {31'd0, bus.grant}, {31'd0, port});
        tick();
        chk({tag, "_rspv"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, port ? 32'd2 : 32'd1);
        chk({tag, "_out"}, bus.rsp_out, exp_out);
        chk({tag, "_zero"}, {31'd0, bus.rsp_zero}, {31'd0, exp_zero});
        if (port) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
        tick();
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        chk({tag, "_idle"}, {30'd0, bus.busy, bus.rsp0_valid | bus.rsp1_valid}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctrl = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctrl = '0;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_grant", {31'd0, bus.grant}, 32'd0);
        chk("rst_rsp_out", bus.rsp_out, 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_valids", {28'd0, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
        rst = 1'b0;
        tick();

        txn("add", 1'b0, 32'd5, 32'd3, 3'b010, 32'd8, 1'b0);
        txn("sub_zero", 1'b1, 32'd7, 32'd7, 3'b011, 32'd0, 1'b1);
        txn("sltu", 1'b1, 32'd2, 32'd9, 3'b100, 32'd1, 1'b0);
        txn("wrap", 1'b0, 32'hFFFF_FFFF, 32'd1, 3'b010, 32'd0, 1'b1);
        txn("not", 1'b0, 32'h0000_FFFF, 32'd0, 3'b111, 32'hFFFF_0000, 1'b0);

        // Fairness: both ports pending continuously after a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 32'd1, 32'd1, 3'b010);
        drive(1'b1, 32'h0000_00F0, 32'h0000_000F, 3'b001);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fair%0d_rdy", i), {30'd0, bus.req1_ready, bus.req0_ready},
                (i % 2) ? 32'd2 : 32'd1);
            tick();
            chk($sformatf("fair%0d_grant", i), {31'd0, bus.grant}, (i % 2) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("fair%0d_out", i), bus.rsp_out, (i % 2) ? 32'h0000_00FF : 32'd2);
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        tick();

        // Backpressure: port 0 response stalls while port 1 waits.
        drive(1'b0, 32'd10, 32'd20, 3'b010);
        tick();
        bus.req0_valid = 1'b0;
        drive(1'b1, 32'h0000_0003, 32'h0000_0005, 3'b000);
        bus.rsp1_ready = 1'b1;
        #1;
        chk("bp_exec_rdy1", {31'd0, bus.req1_ready}, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_rspv", i), {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd1);
            chk($sformatf("bp%0d_out", i), bus.rsp_out, 32'd30);
            chk($sformatf("bp%0d_rdy1", i), {31'd0, bus.req1_ready}, 32'd0);
            tick();
        end
        bus.rsp0_ready = 1'b1;
        tick();
        bus.rsp0_ready = 1'b0;
        chk("bp_rel_busy", {31'd0, bus.busy}, 32'd0);
        chk("bp_rel_rdy1", {31'd0, bus.req1_ready}, 32'd1);
        tick();
        bus.req1_valid = 1'b0;
        chk("bp_grant1", {31'd0, bus.grant}, 32'd1);
        tick();
        chk("bp_out1", bus.rsp_out, 32'd1);
        chk("bp_rspv1", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd2);
        tick();
        bus.rsp1_ready = 1'b0;

        // Reset during EXEC abandons the transaction; next tie goes to port 0.
        drive(1'b1, 32'd4, 32'd4, 3'b010);
        tick();
        bus.req1_valid = 1'b0;
        chk("mid_busy_exec", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        tick();
        chk("mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_valids", {28'd0, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
        chk("mid_rsp_out", bus.rsp_out, 32'd0);
        chk("mid_alu_a", bus.alu_a, 32'd0);
        rst = 1'b0;
        tick();
        chk("mid_no_rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        drive(1'b0, 32'd6, 32'd1, 3'b011);
        drive(1'b1, 32'd9, 32'd9, 3'b011);
        #1;
        chk("mid_tie_rdy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("mid_tie_grant", {31'd0, bus.grant}, 32'd0);
        tick();
        chk("mid_tie_out", bus.rsp_out, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
